mem_port_arbiter: RTL

- Shares one single-port, synchronous-read block-RAM port between two requesters: the MIPS core instruction fetch (I) and data access (D).
- Sits between the mips core and a unified memory, in place of separate inst_mem/data_mem instances.
- Per-cycle grant: D has priority, with an anti-starvation streak limit that guarantees I forward progress.
- Read data returns one cycle after grant, tagged to the owning requester.

---
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (I fetch / D access) arbiter for one synchronous-read RAM port.
// Optional stall counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DW-1:0]     i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DW-1:0]     d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [31:0]       i_stall_cnt,
  output logic [31:0]       d_stall_cnt
);

  localparam int unsigned   SW        = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] StreakMax = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  owner_e        resp_owner_q, resp_owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          unused_addr;

  // D has priority until I has lost MAX_D_STREAK contended cycles in a row.
  assign d_gnt = !rst && d_req && !(i_req && (streak_q == StreakMax));
  assign i_gnt = !rst && i_req && !d_gnt;

  always_comb begin
    mem_en    = i_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = d_gnt ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
    mem_wdata = d_wdata;
  end

  always_comb begin
    streak_d = streak_q;
    if (!i_req || i_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != StreakMax)) begin
      streak_d = streak_q + 1'b1;
    end

    resp_owner_d = OwnNone;
    if (i_gnt) begin
      resp_owner_d = OwnI;
    end else if (d_gnt && !d_we) begin
      resp_owner_d = OwnD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q     <= '0;
      resp_owner_q <= OwnNone;
    end else begin
      streak_q     <= streak_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  assign i_rvalid = (resp_owner_q == OwnI);
  assign d_rvalid = (resp_owner_q == OwnD);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

  // Byte offset and high address bits are deliberately ignored.
  assign unused_addr = ^{i_addr[AW-1:MEM_AW+2], i_addr[1:0],
                         d_addr[AW-1:MEM_AW+2], d_addr[1:0]};

`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_stall_q, i_stall_d;
  logic [31:0] d_stall_q, d_stall_d;

  always_comb begin
    i_stall_d = i_stall_q;
    d_stall_d = d_stall_q;
    if (i_req && !i_gnt && (i_stall_q != 32'hFFFF_FFFF)) i_stall_d = i_stall_q + 32'd1;
    if (d_req && !d_gnt && (d_stall_q != 32'hFFFF_FFFF)) d_stall_d = d_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_stall_q <= '0;
      d_stall_q <= '0;
    end else begin
      i_stall_q <= i_stall_d;
      d_stall_q <= d_stall_d;
    end
  end

  assign i_stall_cnt = i_stall_q;
  assign d_stall_cnt = d_stall_q;
`else
  assign i_stall_cnt = 32'd0;
  assign d_stall_cnt = 32'd0;
`endif

endmodule
